// File: rtl/mux8way16.sv
// Hack 8-way 16-bit multiplexer: a three-level tree of 2-way word muxes, each
// made of gate-level bit cells, plus a synchronously cleared registered output.

module mux_bit (
    input  logic x,
    input  logic y,
    input  logic s,
    output logic out
);
    logic s_n;
    logic x_pass;
    logic y_pass;

    assign s_n    = ~s;
    assign x_pass = x & s_n;
    assign y_pass = y & s;
    assign out    = x_pass | y_pass;
endmodule

module mux2way16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        s,
    output logic [15:0] out
);
    for (genvar i = 0; i < 16; i++) begin : g_bit
        mux_bit u_bit (
            .x   (x[i]),
            .y   (y[i]),
            .s   (s),
            .out (out[i])
        );
    end
endmodule

module mux8way16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out,
    output logic [15:0] out_q
);
    logic [15:0] ab, cd, ef, gh;
    logic [15:0] abcd, efgh;
    logic [15:0] out_d;

    mux2way16 u_ab (.x(a), .y(b), .s(sel[0]), .out(ab));
    mux2way16 u_cd (.x(c), .y(d), .s(sel[0]), .out(cd));
    mux2way16 u_ef (.x(e), .y(f), .s(sel[0]), .out(ef));
    mux2way16 u_gh (.x(g), .y(h), .s(sel[0]), .out(gh));

    mux2way16 u_abcd (.x(ab), .y(cd), .s(sel[1]), .out(abcd));
    mux2way16 u_efgh (.x(ef), .y(gh), .s(sel[1]), .out(efgh));

    mux2way16 u_out (.x(abcd), .y(efgh), .s(sel[2]), .out(out));

    // Reset forces a constant so an unknown sel cannot leak X into the register.
    always_comb begin
        out_d = out;
        if (reset) begin
            out_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        out_q <= out_d;
    end
endmodule

// File: tb/tb_mux8way16.sv
// Scoreboard bench for mux8way16: expected words are queued when stimulus is
// applied and popped when the combinational or registered output is sampled.

module tb_mux8way16;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [2:0]  sel;
    logic [15:0] out;
    logic [15:0] out_q;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_out[$];
    logic [15:0] exp_reg[$];

    mux8way16 dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g),
        .h     (h),
        .sel   (sel),
        .out   (out),
        .out_q (out_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] s);
        logic [15:0] words [8];
        words = '{a, b, c, d, e, f, g, h};
        return words[s];
    endfunction

    task automatic comb_check(input string tag);
        exp_out.push_back(model(sel));
        #1;
        check(tag, out, exp_out.pop_front());
    endtask

    task automatic tick(input string tag);
        exp_reg.push_back(reset ? 16'h0000 : model(sel));
        @(posedge clk);
        #1;
        check(tag, out_q, exp_reg.pop_front());
    endtask

    task automatic load_pattern();
        a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;
        e = 16'h5555; f = 16'h6666; g = 16'h7777; h = 16'h8888;
    endtask

    initial begin
        reset = 1'b1;
        sel   = 3'b000;
        a = '0; b = '0; c = '0; d = '0; e = '0; f = '0; g = '0; h = '0;
        tick("reset_init");

        // Combinational sweep with fixed constants as well as the scoreboard.
        load_pattern();
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            comb_check("sweep");
            check("sweep_const", out, 16'(16'h1111 * (s + 1)));
            #9;
        end

        a = 16'hFFFF; b = 16'h0000;
        c = 16'hA5A5; d = 16'hA5A5; e = 16'hA5A5; f = 16'hA5A5; g = 16'hA5A5; h = 16'hA5A5;
        for (int i = 0; i < 6; i++) begin
            sel = (i % 2 == 0) ? 3'b000 : 3'b001;
            comb_check("bit_indep");
            #3;
        end

        load_pattern();
        sel = 3'b110;
        comb_check("hold_g_old");
        g = 16'hBEEF;
        comb_check("hold_g_new");
        h = 16'h1234;
        comb_check("hold_h_change");
        check("hold_h_const", out, 16'hBEEF);

        load_pattern();
        sel   = 3'b011;
        reset = 1'b1;
        tick("reset_edge1");
        comb_check("reset_out_follows");
        tick("reset_edge2");
        check("reset_out_const", out, 16'h4444);
        sel = 3'bx1x;
        tick("reset_x_sel");
        sel   = 3'b011;
        reset = 1'b0;
        tick("reset_release");
        check("reset_release_const", out_q, 16'h4444);

        sel = 3'b000;
        tick("latency_first");
        sel = 3'b111;
        #1;
        check("latency_hold", out_q, 16'h1111);
        comb_check("latency_out");
        tick("latency_update");
        check("latency_update_const", out_q, 16'h8888);

        sel   = 3'b101;
        reset = 1'b1;
        tick("midstream_reset");
        reset = 1'b0;
        tick("midstream_release");

        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
            e = 16'($urandom); f = 16'($urandom); g = 16'($urandom); h = 16'($urandom);
            sel = 3'($urandom_range(7, 0));
            comb_check("rand_out");
            tick("rand_q");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
